// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver, LSB first, mid-bit sampling.
// Delivers bytes on a valid/ready port and flags framing errors and overruns.
module uart_rx_byte #(
    parameter int BIT_PERIOD = 87,
    parameter int HALF_BIT   = 43
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun
);

    localparam int CW = $clog2(BIT_PERIOD + 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_PERIOD - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t        state_q, state_d;
    logic          rx_meta_q, rx_s_q, rx_s_d_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic          ferr_q, ferr_d;
    logic          ovr_q, ovr_d;
    logic          done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_s_d_q  <= 1'b1;
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
            rx_s_d_q  <= rx_s_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            ovr_q     <= ovr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = valid_q;
        ferr_d  = 1'b0;
        ovr_d   = 1'b0;
        done    = 1'b0;

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (rx_s_d_q && !rx_s_q) begin
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rx_s_q ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_s_q, shift_q[7:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    done    = rx_s_q;
                    ferr_d  = !rx_s_q;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // A held byte that is not being taken this cycle wins over the new one
        if (done) begin
            if (!valid_q || rx_ready) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (valid_q && rx_ready) begin
            valid_d = 1'b0;
        end
    end

    assign rx_data   = data_q;
    assign rx_valid  = valid_q;
    assign frame_err = ferr_q;
    assign overrun   = ovr_q;

endmodule

// File: tb/tb_uart_rx_byte.sv
// Bench for uart_rx_byte: vector table, corner sequences
// and a random byte stream against a queue model.
module tb_uart_rx_byte;

    localparam int BP = 87;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun;

    uart_rx_byte dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx       (rx),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .frame_err(frame_err),
        .overrun  (overrun)
    );

    always #50 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] got[$];
    int n_ferr = 0;
    int n_ovr = 0;
    int vhigh = 0;
    int hold_bad = 0;
    int last_rise = 0;
    int last_edge = 0;
    logic prev_v = 1'b0;
    logic prev_r = 1'b0;
    logic [7:0] prev_d = '0;

    always @(negedge clk) begin
        #1;
        if (rx_valid && !prev_v) last_rise = cyc;
        if (rx_valid) vhigh++;
        if (rx_valid && rx_ready) got.push_back(rx_data);
        if (frame_err) n_ferr++;
        if (overrun) n_ovr++;
        if (prev_v && !prev_r && rx_valid && rx_data !== prev_d)
            hold_bad++;
        prev_v = rx_valid;
        prev_r = rx_ready;
        prev_d = rx_data;
    end

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] d,
                        input logic stop,
                        input int gap);
        rx = 1'b0;
        last_edge = cyc;
        idle(BP);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            idle(BP);
        end
        rx = stop;
        idle(BP);
        rx = 1'b1;
        idle(gap);
    endtask

    typedef struct {
        logic [7:0] d;
        logic       stop;
        int         nb;
        int         nf;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int base, fb, ob, vb;
        logic [7:0] exp_q[$];
        int exp_f;
        string s;

        tbl[0] = '{8'h50, 1'b1, 1, 0};
        tbl[1] = '{8'h00, 1'b1, 1, 0};
        tbl[2] = '{8'hFF, 1'b1, 1, 0};
        tbl[3] = '{8'hA5, 1'b0, 0, 1};
        tbl[4] = '{8'h01, 1'b1, 1, 0};
        tbl[5] = '{8'h80, 1'b1, 1, 0};

        rst_n = 1'b0;
        rx = 1'b1;
        rx_ready = 1'b1;
        idle(4);
        #1;
        chk("rst_valid", 32'(rx_valid), 0);
        chk("rst_data", 32'(rx_data), 0);
        chk("rst_ferr", 32'(frame_err), 0);
        chk("rst_ovr", 32'(overrun), 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(20);

        // 'P' with latency and pulse width
        vb = vhigh;
        base = got.size();
        send(8'h50, 1'b1, 200);
        chk("p_latency", 32'(last_rise - last_edge), 829);
        chk("p_width", 32'(vhigh - vb), 1);
        chk("p_count", 32'(got.size() - base), 1);
        if (got.size() > base)
            chk("p_data", 32'(got[base]), 32'h50);

        foreach (tbl[k]) begin
            base = got.size();
            fb = n_ferr;
            send(tbl[k].d, tbl[k].stop, 200);
            chk($sformatf("v%0d_n", k),
                32'(got.size() - base), 32'(tbl[k].nb));
            chk($sformatf("v%0d_ferr", k),
                32'(n_ferr - fb), 32'(tbl[k].nf));
            if (tbl[k].nb == 1 && got.size() > base)
                chk($sformatf("v%0d_d", k),
                    32'(got[base]), 32'(tbl[k].d));
        end

        // glitch then 0x68
        base = got.size();
        fb = n_ferr;
        rx = 1'b0;
        idle(20);
        rx = 1'b1;
        idle(1000);
        chk("glitch_n", 32'(got.size() - base), 0);
        chk("glitch_ferr", 32'(n_ferr - fb), 0);
        send(8'h68, 1'b1, 200);
        chk("post_glitch_n", 32'(got.size() - base), 1);
        if (got.size() > base)
            chk("post_glitch_d", 32'(got[base]), 32'h68);

        // overrun
        rx_ready = 1'b0;
        base = got.size();
        ob = n_ovr;
        send(8'h69, 1'b1, 0);
        send(8'h6C, 1'b1, 200);
        chk("ovr_pulse", 32'(n_ovr - ob), 1);
        chk("ovr_valid", 32'(rx_valid), 1);
        chk("ovr_data", 32'(rx_data), 32'h69);
        chk("ovr_none", 32'(got.size() - base), 0);
        rx_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("ovr_drop", 32'(rx_valid), 0);
        chk("ovr_taken", 32'(got.size() - base), 1);
        if (got.size() > base)
            chk("ovr_taken_d", 32'(got[base]), 32'h69);
        idle(50);

        // reset during data bit 4
        base = got.size();
        rx = 1'b0;
        idle(BP);
        for (int i = 0; i < 4; i++) begin
            rx = 1'b1;
            idle(BP);
        end
        rx = 1'b0;
        idle(40);
        rst_n = 1'b0;
        rx = 1'b1;
        idle(3);
        #1;
        chk("mid_rst_valid", 32'(rx_valid), 0);
        chk("mid_rst_data", 32'(rx_data), 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(300);
        chk("mid_rst_none", 32'(got.size() - base), 0);
        send(8'h70, 1'b1, 200);
        chk("after_rst_n", 32'(got.size() - base), 1);
        if (got.size() > base)
            chk("after_rst_d", 32'(got[base]), 32'h70);

        // back-to-back string
        s = "Philip Mohr";
        base = got.size();
        fb = n_ferr;
        ob = n_ovr;
        for (int i = 0; i < s.len(); i++)
            send(s[i], 1'b1, 0);
        idle(200);
        chk("str_n", 32'(got.size() - base), 32'(s.len()));
        for (int i = 0; i < s.len() && base + i < got.size(); i++)
            chk($sformatf("str_%0d", i),
                32'(got[base + i]), 32'(s[i]));
        chk("str_flags", 32'(n_ferr - fb + n_ovr - ob), 0);

        // random stream
        base = got.size();
        fb = n_ferr;
        ob = n_ovr;
        exp_f = 0;
        for (int i = 0; i < 30; i++) begin
            logic [7:0] d;
            logic st;
            d = 8'($urandom);
            st = ($urandom_range(0, 7) != 0);
            if (st) exp_q.push_back(d);
            else exp_f++;
            send(d, st, st ? $urandom_range(0, 150)
                           : $urandom_range(5, 150));
        end
        idle(300);
        chk("rnd_n", 32'(got.size() - base), 32'(exp_q.size()));
        chk("rnd_ferr", 32'(n_ferr - fb), 32'(exp_f));
        chk("rnd_ovr", 32'(n_ovr - ob), 0);
        for (int i = 0; i < exp_q.size() && base + i < got.size(); i++)
            chk($sformatf("rnd_%0d", i),
                32'(got[base + i]), 32'(exp_q[i]));

        chk("hold_stable", 32'(hold_bad), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
